i2c_capture_ctrl: RTL and testbench
===================================

Name: i2c_capture_ctrl

Overview:
- Sequences the output of the passive I2C bus listener (byte_ready/sop/eot pulses, 9-bit {data,ack} bytes) into a framed capture FIFO.
- Applies a masked 7-bit address filter and writes start, data and end-marker entries.
- Guarantees every accepted packet is closed, including under overflow and repeated start.
- Sits between the listener and a host/UART drain.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 4.
LEVEL_W, 5, width of fifo_level; equals log2(DEPTH)+1.
CAPTURE_NAK, 0, 1 = accept packets whose address byte was NAK'd.

Ports:
sysclk  in  1  single clock; all logic on posedge.
reset  in  1  synchronous, active-high.
enable  in  1  capture enable; sampled only when an address byte arrives.
match_addr  in  7  address to capture.
match_mask  in  7  1 = compare this bit; all-zero matches every address.
byte_in  in  9  listener byte: [8:1] data (MSB first), [0] ack (0 = ACK, 1 = NAK).
byte_ready  in  1  one-cycle pulse; byte_in valid.
sop  in  1  one-cycle start / repeated-start pulse.
eot  in  1  one-cycle stop pulse.
rd_valid  out  1  FIFO not empty; rd_data valid (first-word fall-through).
rd_data  out  11  entry {type[1:0], payload[8:0]}.
rd_ack  in  1  pop head entry; ignored when rd_valid = 0.
fifo_level  out  LEVEL_W  entries stored.
pkt_count  out  16  accepted packets, saturating.
drop_count  out  16  packets rejected for lack of space, saturating.

Behaviour:
- Reset: FIFO flushed, rd_valid = 0, fifo_level = 0, counters = 0, state IDLE, byte/ovf registers = 0. Reset mid-packet discards the packet and writes no end marker.
- Entry types:
  - 00 = data, payload = byte_in.
  - 01 = start, payload = address byte_in.
  - 10 = end by stop, payload = {ovf, nbytes[7:0]}.
  - 11 = end by repeated start, same payload.
- nbytes counts data bytes written, saturating at 255. ovf = 1 if any data byte of the packet was dropped.
- Events are mutually exclusive, and the listener spaces them at least 2 cycles apart. The controller performs at most one FIFO write per cycle.
- Latency: an event pulse in cycle N causes a write at the end of cycle N. The entry is visible (rd_valid/fifo_level) in cycle N+1.
- States: IDLE, ADDR, CAPTURE, DROP.
  - IDLE: sop -> ADDR. byte_ready and eot are ignored.
  - ADDR, byte_ready: match = ((byte_in[8:2] ^ match_addr) & match_mask) == 0 and enable and (byte_in[0] == 0 or CAPTURE_NAK).
    - If match and free >= 2: write start, pkt_count++, nbytes = 0, ovf = 0 -> CAPTURE.
    - If match and free < 2: drop_count++ -> DROP.
    - If no match: -> DROP, with no counter change.
  - ADDR, eot -> IDLE. ADDR, sop stays in ADDR.
  - CAPTURE, byte_ready: if free >= 2, write data and nbytes++. Otherwise set ovf and discard the byte. This keeps one slot reserved for the end marker.
  - CAPTURE, eot: write type 10 -> IDLE.
  - CAPTURE, sop: write type 11 -> ADDR.
  - DROP: eot -> IDLE. sop -> ADDR. byte_ready is ignored.
- free = DEPTH - fifo_level, using the level before any same-cycle pop; this is conservative. Push and pop in the same cycle are both performed and the level is unchanged.
- The end-marker write always succeeds, because of the reserved slot.
- rd_ack with rd_valid = 0 has no effect. The read pointer wraps modulo DEPTH.

Test Plan:
- Mask 7'h7F, match_addr 7'h50: sop, byte 0xA0/ACK, data 0x12 and 0x34 ACK, eot -> entries {01,0x140}, {00,0x024}, {00,0x068}, {10,0x002}; pkt_count = 1; rd_valid rises the cycle after the first byte_ready.
- Address 0x51 with mask 7'h7F -> DROP; subsequent bytes and eot write nothing; fifo_level stays 0; counters unchanged. The same bus traffic with mask 0 is captured.
- DEPTH 4, no reads: start + 5 data + eot -> start, 2 data, end {10, ovf=1, nbytes=2}; fifo_level = 4. A second packet with the FIFO full -> drop_count = 1, no writes.
- Repeated start: sop, addr 0xA0, data 0x55, sop, addr 0xA1, data 0x99, eot -> end type 11 with nbytes = 1, new start {01,0x142}, final end type 10; pkt_count = 2.
- Pop on the same cycle as a data write at level 3 -> level stays 3 and ordering is preserved. Reset asserted mid-CAPTURE -> level 0, rd_valid 0, a following byte_ready writes nothing until the next sop.
- CAPTURE_NAK = 0, address byte with NAK -> dropped. With enable = 0 at the address byte -> dropped; enable toggled mid-packet has no effect.

Source files
------------

// File: rtl/i2c_capture_if.sv
// Bus bundle between the I2C listener / host drain and the capture controller.
// The master side drives listener events and pops entries. The slave side is the controller.
interface i2c_capture_if;
    logic [8:0]  byte_in;
    logic        byte_ready;
    logic        sop;
    logic        eot;
    logic        rd_valid;
    logic [10:0] rd_data;
    logic        rd_ack;

    modport master (
        output byte_in, byte_ready, sop, eot, rd_ack,
        input  rd_valid, rd_data
    );

    modport slave (
        input  byte_in, byte_ready, sop, eot, rd_ack,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/i2c_capture_ctrl.sv
// Frames passive I2C listener bytes into a capture FIFO of start/data/end entries.
// An address filter is applied, and one slot is always kept free for the end marker.
module i2c_capture_ctrl #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned LEVEL_W     = 5,
    parameter bit          CAPTURE_NAK = 1'b0
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               enable,
    input  logic [6:0]         match_addr,
    input  logic [6:0]         match_mask,
    i2c_capture_if.slave       bus,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic [15:0]        pkt_count,
    output logic [15:0]        drop_count
);
    localparam int unsigned        PTR_W    = $clog2(DEPTH);
    localparam logic [LEVEL_W-1:0] ROOM_MAX = LEVEL_W'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, ADDR, CAPTURE, DROP} state_t;

    state_t             state_q, state_d;
    logic [10:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LEVEL_W-1:0] level_q;
    logic [7:0]         nbytes_q;
    logic               ovf_q;

    logic        push, pop, room, addr_hit;
    logic [10:0] push_entry;
    logic        pkt_inc, drop_inc, nb_clr, nb_inc, ovf_set;

    // free >= 2 is judged on the level before any same-cycle pop
    assign room     = (level_q <= ROOM_MAX);
    assign addr_hit = (((bus.byte_in[8:2] ^ match_addr) & match_mask) == '0)
                      && enable && (!bus.byte_in[0] || CAPTURE_NAK);
    assign pop      = bus.rd_ack && (level_q != '0);

    assign bus.rd_valid = (level_q != '0);
    assign bus.rd_data  = mem[rd_ptr];
    assign fifo_level   = level_q;

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        push_entry = '0;
        pkt_inc    = 1'b0;
        drop_inc   = 1'b0;
        nb_clr     = 1'b0;
        nb_inc     = 1'b0;
        ovf_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sop) state_d = ADDR;
            end
            ADDR: begin
                if (bus.byte_ready) begin
                    if (addr_hit && room) begin
                        push       = 1'b1;
                        push_entry = {2'b01, bus.byte_in};
                        pkt_inc    = 1'b1;
                        nb_clr     = 1'b1;
                        state_d    = CAPTURE;
                    end else begin
                        drop_inc = addr_hit;
                        state_d  = DROP;
                    end
                end else if (bus.eot) begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                if (bus.byte_ready) begin
                    if (room) begin
                        push       = 1'b1;
                        push_entry = {2'b00, bus.byte_in};
                        nb_inc     = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (bus.eot) begin
                    push       = 1'b1;
                    push_entry = {2'b10, ovf_q, nbytes_q};
                    state_d    = IDLE;
                end else if (bus.sop) begin
                    push       = 1'b1;
                    push_entry = {2'b11, ovf_q, nbytes_q};
                    state_d    = ADDR;
                end
            end
            DROP: begin
                if (bus.eot)      state_d = IDLE;
                else if (bus.sop) state_d = ADDR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            nbytes_q   <= '0;
            ovf_q      <= 1'b0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LEVEL_W'(1);
                2'b01:   level_q <= level_q - LEVEL_W'(1);
                default: level_q <= level_q;
            endcase
            if (nb_clr) begin
                nbytes_q <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (nb_inc && nbytes_q != '1) nbytes_q <= nbytes_q + 8'd1;
                if (ovf_set)                  ovf_q    <= 1'b1;
            end
            if (pkt_inc && pkt_count != '1)   pkt_count  <= pkt_count + 16'd1;
            if (drop_inc && drop_count != '1) drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_i2c_capture_ctrl.sv
// Directed bench for i2c_capture_ctrl: a 16-deep and a 4-deep instance share listener traffic.
// Each instance has its own read-acknowledge input.
module tb_i2c_capture_ctrl;
    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [6:0] match_addr = 7'h50;
    logic [6:0] match_mask = 7'h7F;
    logic [8:0] byte_in = '0;
    logic       byte_ready = 1'b0, sop = 1'b0, eot = 1'b0;
    logic       ack16 = 1'b0, ack4 = 1'b0;

    logic [4:0]  level16;
    logic [2:0]  level4;
    logic [15:0] pkt16, drop16, pkt4, drop4;

    int checks = 0;
    int failures = 0;

    i2c_capture_if bus16 ();
    i2c_capture_if bus4 ();

    assign bus16.byte_in = byte_in;  assign bus4.byte_in = byte_in;
    assign bus16.byte_ready = byte_ready;  assign bus4.byte_ready = byte_ready;
    assign bus16.sop = sop;  assign bus4.sop = sop;
    assign bus16.eot = eot;  assign bus4.eot = eot;
    assign bus16.rd_ack = ack16;  assign bus4.rd_ack = ack4;

    i2c_capture_ctrl #(.DEPTH(16), .LEVEL_W(5), .CAPTURE_NAK(1'b0)) d16 (
        .sysclk(sysclk), .reset(reset), .enable(enable),
        .match_addr(match_addr), .match_mask(match_mask), .bus(bus16.slave),
        .fifo_level(level16), .pkt_count(pkt16), .drop_count(drop16)
    );

    i2c_capture_ctrl #(.DEPTH(4), .LEVEL_W(3), .CAPTURE_NAK(1'b0)) d4 (
        .sysclk(sysclk), .reset(reset), .enable(enable),
        .match_addr(match_addr), .match_mask(match_mask), .bus(bus4.slave),
        .fifo_level(level4), .pkt_count(pkt4), .drop_count(drop4)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1; ack16 = 1'b0; ack4 = 1'b0;
        @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic send_sop();
        @(negedge sysclk); sop = 1'b1;
        @(negedge sysclk); sop = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic send_eot();
        @(negedge sysclk); eot = 1'b1;
        @(negedge sysclk); eot = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic nak);
        @(negedge sysclk); byte_in = {d, nak}; byte_ready = 1'b1;
        @(negedge sysclk); byte_ready = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic pop16(input string tag, input logic [10:0] exp);
        @(negedge sysclk);
        chk({tag, "_valid"}, 16'(bus16.rd_valid), 16'd1);
        chk(tag, 16'(bus16.rd_data), 16'(exp));
        ack16 = 1'b1;
        @(negedge sysclk); ack16 = 1'b0;
    endtask

    task automatic pop4(input string tag, input logic [10:0] exp);
        @(negedge sysclk);
        chk({tag, "_valid"}, 16'(bus4.rd_valid), 16'd1);
        chk(tag, 16'(bus4.rd_data), 16'(exp));
        ack4 = 1'b1;
        @(negedge sysclk); ack4 = 1'b0;
    endtask

    initial begin
        // Reset state of both instances
        do_reset();
        chk("rst_valid16", 16'(bus16.rd_valid), 16'd0);
        chk("rst_level16", 16'(level16), 16'd0);
        chk("rst_pkt16", pkt16, 16'd0);
        chk("rst_drop16", drop16, 16'd0);
        chk("rst_level4", 16'(level4), 16'd0);

        // Basic capture: addr 0x50, two data bytes, stop
        send_sop();
        chk("s1_valid_pre", 16'(bus16.rd_valid), 16'd0);
        @(negedge sysclk); byte_in = {8'hA0, 1'b0}; byte_ready = 1'b1;
        @(negedge sysclk); byte_ready = 1'b0;
        chk("s1_valid_lat", 16'(bus16.rd_valid), 16'd1);
        chk("s1_level_lat", 16'(level16), 16'd1);
        @(negedge sysclk);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_eot();
        chk("s1_level", 16'(level16), 16'd4);
        chk("s1_pkt", pkt16, 16'd1);
        pop16("s1_start", {2'b01, 9'h140});
        pop16("s1_d0", {2'b00, 9'h024});
        pop16("s1_d1", {2'b00, 9'h068});
        pop16("s1_end", {2'b10, 9'h002});
        @(negedge sysclk);
        chk("s1_empty", 16'(bus16.rd_valid), 16'd0);

        // Address 0x51 rejected under full mask, accepted under zero mask
        do_reset();
        send_sop(); send_byte(8'hA2, 1'b0); send_byte(8'h11, 1'b0); send_eot();
        chk("s2_nomatch_level", 16'(level16), 16'd0);
        chk("s2_nomatch_pkt", pkt16, 16'd0);
        chk("s2_nomatch_drop", drop16, 16'd0);
        match_mask = 7'h00;
        send_sop(); send_byte(8'hA2, 1'b0); send_byte(8'h11, 1'b0); send_eot();
        chk("s2_mask0_level", 16'(level16), 16'd3);
        chk("s2_mask0_pkt", pkt16, 16'd1);
        pop16("s2_start", {2'b01, 9'h144});
        pop16("s2_d0", {2'b00, 9'h022});
        pop16("s2_end", {2'b10, 9'h001});
        match_mask = 7'h7F;

        // 4-deep overflow: only two data bytes fit, then a packet is dropped
        do_reset();
        send_sop(); send_byte(8'hA0, 1'b0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        send_eot();
        chk("s3_level", 16'(level4), 16'd4);
        chk("s3_pkt", pkt4, 16'd1);
        send_sop(); send_byte(8'hA0, 1'b0); send_byte(8'hEE, 1'b0); send_eot();
        chk("s3_full_level", 16'(level4), 16'd4);
        chk("s3_full_drop", drop4, 16'd1);
        chk("s3_full_pkt", pkt4, 16'd1);
        pop4("s3_start", {2'b01, 9'h140});
        pop4("s3_d0", {2'b00, 9'h002});
        pop4("s3_d1", {2'b00, 9'h004});
        pop4("s3_end", {2'b10, 9'h102});
        @(negedge sysclk);
        chk("s3_empty", 16'(bus4.rd_valid), 16'd0);

        // Repeated start closes the first packet with type 11
        do_reset();
        send_sop(); send_byte(8'hA0, 1'b0); send_byte(8'h55, 1'b0);
        send_sop(); send_byte(8'hA1, 1'b0); send_byte(8'h99, 1'b0);
        send_eot();
        chk("s4_level", 16'(level16), 16'd6);
        chk("s4_pkt", pkt16, 16'd2);
        pop16("s4_start0", {2'b01, 9'h140});
        pop16("s4_d0", {2'b00, 9'h0AA});
        pop16("s4_rs_end", {2'b11, 9'h001});
        pop16("s4_start1", {2'b01, 9'h142});
        pop16("s4_d1", {2'b00, 9'h132});
        pop16("s4_end", {2'b10, 9'h001});

        // Pop and data write in the same cycle at level 3
        do_reset();
        send_sop(); send_byte(8'hA0, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        chk("s5_level_pre", 16'(level16), 16'd3);
        chk("s5_head", 16'(bus16.rd_data), 16'({2'b01, 9'h140}));
        @(negedge sysclk); byte_in = {8'h33, 1'b0}; byte_ready = 1'b1; ack16 = 1'b1;
        @(negedge sysclk); byte_ready = 1'b0; ack16 = 1'b0;
        chk("s5_level_same", 16'(level16), 16'd3);
        pop16("s5_d0", {2'b00, 9'h022});
        pop16("s5_d1", {2'b00, 9'h044});
        pop16("s5_d2", {2'b00, 9'h066});
        send_byte(8'h44, 1'b0);
        chk("s5_level_mid", 16'(level16), 16'd1);
        // Reset while in CAPTURE discards everything
        do_reset();
        chk("s5_rst_level", 16'(level16), 16'd0);
        chk("s5_rst_valid", 16'(bus16.rd_valid), 16'd0);
        send_byte(8'h77, 1'b0); send_eot();
        chk("s5_post_rst", 16'(level16), 16'd0);
        send_sop(); send_byte(8'hA0, 1'b0);
        chk("s5_new_pkt", 16'(level16), 16'd1);

        // NAK'd address and disabled capture are dropped; enable only matters at the address
        do_reset();
        send_sop(); send_byte(8'hA0, 1'b1); send_byte(8'h01, 1'b0); send_eot();
        chk("s6_nak_level", 16'(level16), 16'd0);
        chk("s6_nak_drop", drop16, 16'd0);
        enable = 1'b0;
        send_sop(); send_byte(8'hA0, 1'b0); send_byte(8'h01, 1'b0); send_eot();
        chk("s6_dis_level", 16'(level16), 16'd0);
        chk("s6_dis_pkt", pkt16, 16'd0);
        enable = 1'b1;
        send_sop(); send_byte(8'hA0, 1'b0);
        enable = 1'b0;
        send_byte(8'h66, 1'b0); send_eot();
        enable = 1'b1;
        chk("s6_tog_level", 16'(level16), 16'd3);
        chk("s6_tog_pkt", pkt16, 16'd1);
        pop16("s6_start", {2'b01, 9'h140});
        pop16("s6_d0", {2'b00, 9'h0CC});
        pop16("s6_end", {2'b10, 9'h001});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
